// File: rtl/mau_pkg.sv
// Shared definitions for mem_access_unit: size encodings, FSM states and the
// lane merge/extract helpers used by the store and load datapaths.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } mau_state_t;

    // Size code 11 behaves exactly like a word access.
    function automatic logic size_is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic res;
        case (size)
            SZ_BYTE: res = 1'b0;
            SZ_HALF: res = addr[0];
            default: res = (addr != 2'b00);
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                               input logic [1:0] size, input logic [1:0] addr);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: res[{addr, 3'b000} +: 8] = data[7:0];
            SZ_HALF: res[{addr[1], 4'b0000} +: 16] = data[15:0];
            default: res = data;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] addr, input logic sgn);
        logic [31:0] res;
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr, 3'b000} +: 8];
        h = word[{addr[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: res = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            SZ_HALF: res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mau_if.sv
// Handshake bundles of mem_access_unit: CPU request/response side and
// the word-wide data-memory side.
interface mau_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface mau_mem_if;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [31:0] mem_readData;

    modport master (
        output mem_address, mem_writeData, mem_memWrite, mem_memRead,
        input  mem_readData
    );
    modport slave (
        input  mem_address, mem_writeData, mem_memWrite, mem_memRead,
        output mem_readData
    );
endinterface

// File: rtl/mau_lane_align.sv
// Combinational lane logic: merges store data into a memory word and
// extracts/extends load data from it.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_signed,
    output logic [31:0] o_merged,
    output logic [31:0] o_extracted
);

    assign o_merged    = lane_merge(i_word, i_data, i_size, i_lane);
    assign o_extracted = lane_extract(i_word, i_size, i_lane, i_signed);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer for a single-ported word-wide data memory (RMW for sub-word stores).
// Build option MAU_ALIGN_CHECK_EN: reject misaligned requests instead of force-aligning them.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int MEM_AW = 5
) (
    input  logic      Clk,
    input  logic      Reset,
    mau_req_if.slave  req_bus,
    mau_mem_if.master mem_bus
);

    mau_state_t        r_state;
    mau_state_t        w_next;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_lane;
    logic [MEM_AW-1:0] r_idx;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdword;
    logic              r_err;

    logic              w_accept;
    logic              w_misalign;
    logic              w_req_ready;
    logic              w_resp_valid;
    logic              w_rd;
    logic              w_wr;
    logic [31:0]       w_merged;
    logic [31:0]       w_extract;
    logic              w_unused;

    assign w_accept = req_bus.req_valid && (r_state == ST_IDLE);
    assign w_unused = ^{req_bus.req_addr[31:MEM_AW+2]};

`ifdef MAU_ALIGN_CHECK_EN
    assign w_misalign = is_misaligned(req_bus.req_size, req_bus.req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_lane   <= 2'b00;
            r_idx    <= '0;
            r_wdata  <= 32'd0;
            r_rdword <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= req_bus.req_write;
                r_size   <= req_bus.req_size;
                r_signed <= req_bus.req_signed;
                r_lane   <= req_bus.req_addr[1:0];
                r_idx    <= req_bus.req_addr[MEM_AW+1:2];
                r_wdata  <= req_bus.req_wdata;
                r_err    <= w_misalign;
            end
            // The word read in RD feeds both the RMW merge and the held load response.
            if (r_state == ST_RD) begin
                r_rdword <= mem_bus.mem_readData;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_bus.req_valid) begin
                    if (w_misalign) begin
                        w_next = ST_RESP;
                    end else if (req_bus.req_write && size_is_word(req_bus.req_size)) begin
                        w_next = ST_WR;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_RD: begin
                w_rd   = 1'b1;
                w_next = r_write ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                w_wr   = 1'b1;
                w_next = ST_RESP;
            end
            ST_RESP: begin
                w_resp_valid = 1'b1;
                if (req_bus.resp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    mau_lane_align u_lane_align (
        .i_word      (r_rdword),
        .i_data      (r_wdata),
        .i_size      (r_size),
        .i_lane      (r_lane),
        .i_signed    (r_signed),
        .o_merged    (w_merged),
        .o_extracted (w_extract)
    );

    assign req_bus.req_ready  = w_req_ready;
    assign req_bus.resp_valid = w_resp_valid;
    assign req_bus.resp_err   = w_resp_valid & r_err;
    assign req_bus.resp_rdata = (w_resp_valid && !r_write && !r_err) ? w_extract : 32'd0;

    // Strobes come straight from the state so an async reset kills a pending write.
    assign mem_bus.mem_memRead   = w_rd;
    assign mem_bus.mem_memWrite  = w_wr;
    assign mem_bus.mem_writeData = w_wr ? w_merged : 32'd0;
    assign mem_bus.mem_address   = {{(32-MEM_AW){1'b0}}, r_idx};

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// hold/reset sequences, and random traffic against a byte-level memory model.
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int MEM_AW = 5;
    localparam int NWORDS = 32;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;

    mau_req_if rq ();
    mau_mem_if mb ();

    mem_access_unit #(.MEM_AW(MEM_AW)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .req_bus (rq),
        .mem_bus (mb)
    );

    always #5 Clk = ~Clk;

    // Memory attached to the DUT: combinational read, write sampled on negedge.
    logic [31:0] dmem [NWORDS];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int last_wr_idx = -1;

    assign mb.mem_readData = dmem[mb.mem_address[4:0]];

    always @(negedge Clk) begin
        if (mb.mem_memRead) rd_cnt <= rd_cnt + 1;
        if (mb.mem_memWrite) begin
            wr_cnt      <= wr_cnt + 1;
            last_wr_idx <= int'(mb.mem_address);
        end
        if (mb.mem_memWrite && !mb.mem_memRead) dmem[mb.mem_address[4:0]] <= mb.mem_writeData;
    end

    // Reference model state: what the memory should contain.
    logic [31:0] ref_mem [NWORDS];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Byte-granular view of a request: mask/shift arithmetic on the word.
    task automatic ref_access(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er,
                              output int lat, output int nrd, output int nwr);
        int nb, idx, off;
        logic [63:0] lowmask, mask, v;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        idx = int'(addr / 4) % NWORDS;
        off = int'(addr % 4);
        rd = 32'd0; er = 1'b0; lat = 2; nrd = 0; nwr = 0;
`ifdef MAU_ALIGN_CHECK_EN
        if (off % nb != 0) begin
            er  = 1'b1;
            lat = 1;
            return;
        end
`endif
        off     = off - (off % nb);
        lowmask = (64'd1 << (8 * nb)) - 64'd1;
        mask    = lowmask << (8 * off);
        if (wr) begin
            v = ({32'd0, ref_mem[idx]} & ~mask) | (({32'd0, wd} << (8 * off)) & mask);
            ref_mem[idx] = v[31:0];
            nwr = 1;
            nrd = (nb == 4) ? 0 : 1;
            lat = (nb == 4) ? 2 : 3;
        end else begin
            v = ({32'd0, ref_mem[idx]} >> (8 * off)) & lowmask;
            if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~lowmask;
            rd  = v[31:0];
            nrd = 1;
        end
    endtask

    // One complete transaction; latency counted from the accept cycle.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int nrd, output int nwr);
        int r0, w0;
        @(posedge Clk); #1;
        r0 = rd_cnt;
        w0 = wr_cnt;
        rq.req_valid  = 1'b1;
        rq.req_write  = wr;
        rq.req_size   = sz;
        rq.req_signed = sg;
        rq.req_addr   = a;
        rq.req_wdata  = wd;
        @(posedge Clk); #1;
        rq.req_valid = 1'b0;
        lat = 1;
        while (!rq.resp_valid && lat < 8) begin
            @(posedge Clk); #1;
            lat++;
        end
        repeat (hold) begin
            @(posedge Clk); #1;
        end
        rd = rq.resp_rdata;
        er = rq.resp_err;
        rq.resp_ready = 1'b1;
        @(posedge Clk); #1;
        rq.resp_ready = 1'b0;
        nrd = rd_cnt - r0;
        nwr = wr_cnt - w0;
    endtask

    initial begin
        vec_t        tbl [22];
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat, nrd, nwr, mlat, mnrd, mnwr, r0;
        logic        wr, sg;
        logic [1:0]  sz;
        logic [31:0] a, wd;

        Reset         = 1'b0;
        rq.req_valid  = 1'b0;
        rq.req_write  = 1'b0;
        rq.req_size   = 2'b00;
        rq.req_signed = 1'b0;
        rq.req_addr   = 32'd0;
        rq.req_wdata  = 32'd0;
        rq.resp_ready = 1'b0;
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = 32'd0;

        repeat (2) @(posedge Clk);
        #1;
        chk("rst req_ready", 32'(rq.req_ready), 32'd1);
        chk("rst resp_valid", 32'(rq.resp_valid), 32'd0);
        chk("rst resp_rdata", rq.resp_rdata, 32'd0);
        chk("rst resp_err", 32'(rq.resp_err), 32'd0);
        chk("rst memRead", 32'(mb.mem_memRead), 32'd0);
        chk("rst memWrite", 32'(mb.mem_memWrite), 32'd0);
        chk("rst mem_address", mb.mem_address, 32'd0);
        chk("rst writeData", mb.mem_writeData, 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;

        // Bring the attached memory to a known all-zero state through the DUT.
        for (int i = 0; i < NWORDS; i++) run_req(1'b1, SZ_WORD, 1'b0, 32'(i * 4), 32'd0, 0, rd, er, lat, nrd, nwr);

        //             wr    sz     sg    addr     wdata          exp_rd         err  lat rd wr
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0, 1};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h0C, 32'h11223344, 32'h00000000, 1'b0, 2, 0, 1};
        tbl[3]  = '{1'b1, 2'd2, 1'b0, 32'h04, 32'h80007FFF, 32'h00000000, 1'b0, 2, 0, 1};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h0D, 32'h000000AA, 32'h00000000, 1'b0, 3, 1, 1};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h0C, 32'h0,        32'h1122AA44, 1'b0, 2, 1, 0};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 32'h0D, 32'h0,        32'h000000AA, 1'b0, 2, 1, 0};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 32'h0D, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 1, 0};
        tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h06, 32'h0,        32'hFFFF8000, 1'b0, 2, 1, 0};
        tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'h04, 32'h0,        32'h00007FFF, 1'b0, 2, 1, 0};
`ifdef MAU_ALIGN_CHECK_EN
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h05, 32'h0,        32'h00000000, 1'b1, 1, 0, 0};
`else
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h05, 32'h0,        32'h80007FFF, 1'b0, 2, 1, 0};
`endif
        tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h80, 32'h12345678, 32'h00000000, 1'b0, 2, 0, 1};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        32'h12345678, 1'b0, 2, 1, 0};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h82, 32'h0000BEEF, 32'h00000000, 1'b0, 3, 1, 1};
        tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        32'hBEEF5678, 1'b0, 2, 1, 0};
        tbl[15] = '{1'b0, 2'd3, 1'b1, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0};
        tbl[16] = '{1'b0, 2'd1, 1'b1, 32'h0E, 32'h0,        32'h00001122, 1'b0, 2, 1, 0};
`ifdef MAU_ALIGN_CHECK_EN
        tbl[17] = '{1'b0, 2'd1, 1'b0, 32'h83, 32'h0,        32'h00000000, 1'b1, 1, 0, 0};
`else
        tbl[17] = '{1'b0, 2'd1, 1'b0, 32'h83, 32'h0,        32'h0000BEEF, 1'b0, 2, 1, 0};
`endif
        tbl[18] = '{1'b1, 2'd0, 1'b0, 32'h83, 32'hFFFFFF55, 32'h00000000, 1'b0, 3, 1, 1};
        tbl[19] = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        32'h55EF5678, 1'b0, 2, 1, 0};
`ifdef MAU_ALIGN_CHECK_EN
        tbl[20] = '{1'b1, 2'd1, 1'b0, 32'h01, 32'h00001234, 32'h00000000, 1'b1, 1, 0, 0};
        tbl[21] = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        32'h55EF5678, 1'b0, 2, 1, 0};
`else
        tbl[20] = '{1'b1, 2'd1, 1'b0, 32'h01, 32'h00001234, 32'h00000000, 1'b0, 3, 1, 1};
        tbl[21] = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        32'h55EF1234, 1'b0, 2, 1, 0};
`endif

        foreach (tbl[i]) begin
            run_req(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, 0, rd, er, lat, nrd, nwr);
            ref_access(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, mrd, mer, mlat, mnrd, mnwr);
            chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("vec%0d memRead cycles", i), 32'(nrd), 32'(tbl[i].exp_nrd));
            chk($sformatf("vec%0d memWrite cycles", i), 32'(nwr), 32'(tbl[i].exp_nwr));
            if (tbl[i].exp_nwr == 1)
                chk($sformatf("vec%0d write index", i), 32'(last_wr_idx), (tbl[i].addr >> 2) & 32'd31);
        end

        // Back-pressure: response held for 4 cycles, a second request must not start.
        @(posedge Clk); #1;
        rq.req_valid = 1'b1; rq.req_write = 1'b0; rq.req_size = SZ_WORD; rq.req_addr = 32'h08;
        @(posedge Clk); #1;
        rq.req_valid = 1'b0;
        @(posedge Clk); #1;
        r0 = rd_cnt;
        rq.req_valid = 1'b1; rq.req_write = 1'b0; rq.req_size = SZ_WORD; rq.req_addr = 32'h0C;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold%0d resp_valid", k), 32'(rq.resp_valid), 32'd1);
            chk($sformatf("hold%0d resp_rdata", k), rq.resp_rdata, 32'hDEADBEEF);
            chk($sformatf("hold%0d req_ready", k), 32'(rq.req_ready), 32'd0);
            @(posedge Clk); #1;
        end
        chk("hold no second access", 32'(rd_cnt - r0), 32'd0);
        rq.req_valid  = 1'b0;
        rq.resp_ready = 1'b1;
        @(posedge Clk); #1;
        rq.resp_ready = 1'b0;
        chk("hold release req_ready", 32'(rq.req_ready), 32'd1);
        chk("hold release resp_valid", 32'(rq.resp_valid), 32'd0);

        // Reset asserted during the WR cycle of a word store: the write must be lost.
        @(posedge Clk); #1;
        rq.req_valid = 1'b1; rq.req_write = 1'b1; rq.req_size = SZ_WORD;
        rq.req_addr = 32'h10; rq.req_wdata = 32'hCAFEF00D;
        @(posedge Clk); #1;
        rq.req_valid = 1'b0;
        chk("wr-abort memWrite before reset", 32'(mb.mem_memWrite), 32'd1);
        Reset = 1'b0;
        #1;
        chk("wr-abort memWrite after reset", 32'(mb.mem_memWrite), 32'd0);
        @(negedge Clk);
        @(posedge Clk); #1;
        Reset = 1'b1;
        #1;
        chk("wr-abort req_ready", 32'(rq.req_ready), 32'd1);
        chk("wr-abort resp_valid", 32'(rq.resp_valid), 32'd0);
        chk("wr-abort word4", dmem[4], 32'd0);

        // Random traffic, including addresses that wrap past the 32-word memory.
        for (int n = 0; n < 160; n++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 255));
            wd = $urandom;
            run_req(wr, sz, sg, a, wd, int'($urandom_range(0, 2)), rd, er, lat, nrd, nwr);
            ref_access(wr, sz, sg, a, wd, mrd, mer, mlat, mnrd, mnwr);
            chk($sformatf("rnd%0d rdata a=%h sz=%0d", n, a, sz), rd, mrd);
            chk($sformatf("rnd%0d err", n), 32'(er), 32'(mer));
            chk($sformatf("rnd%0d latency", n), 32'(lat), 32'(mlat));
            chk($sformatf("rnd%0d memRead cycles", n), 32'(nrd), 32'(mnrd));
            chk($sformatf("rnd%0d memWrite cycles", n), 32'(nwr), 32'(mnwr));
        end

        @(posedge Clk); #1;
        for (int i = 0; i < NWORDS; i++) chk($sformatf("final word%0d", i), dmem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store sequencer that drives the single-ported, word-wide data memory on behalf of the CPU datapath.
- Accepts byte, halfword and word requests at byte addresses over a valid/ready handshake.
- Issues word-granular memRead/memWrite cycles; sub-word stores use read-modify-write.
- Returns aligned, sign- or zero-extended load data over a valid/ready response handshake.

Parameters:
- MEM_AW, 5, word-address width of the attached memory (32 words); the word index wraps modulo 2^MEM_AW.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_signed  input  1  sign-extend load result; ignored for word loads and stores.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  response available; held until taken.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  load result; 0 for stores.
- resp_err  output  1  request was misaligned; no memory access was made.
- mem_address  output  32  word index, zero-extended, = req_addr[MEM_AW+1:2].
- mem_writeData  output  32  word to write.
- mem_memWrite  output  1  write strobe; the memory samples it on negedge Clk.
- mem_memRead  output  1  read enable.
- mem_readData  input  32  combinational read data from the memory.

Behaviour:
- Reset (async, Reset low):
  - state = IDLE.
  - All outputs 0, except req_ready = 1.
  - Captured request registers cleared.
  - An in-flight write is aborted: mem_memWrite drops immediately, so no write occurs at the following negedge.
- FSM states: IDLE, RD, WR, RESP.
- IDLE, on req_valid & req_ready:
  - Capture write, size, signed, addr and wdata.
  - Misaligned request (size 01 with addr[0]=1, or word with addr[1:0]≠0): go to RESP with err=1.
  - Otherwise, word store: go to WR.
  - Otherwise, load or sub-word store: go to RD.
- RD:
  - mem_memRead = 1, mem_memWrite = 0; mem_readData is registered at posedge.
  - Load: go to RESP.
  - Sub-word store: go to WR.
- WR:
  - mem_memWrite = 1, mem_memRead = 0.
  - mem_writeData = captured word with the target lane(s) replaced.
  - Word store writes wdata directly.
  - Next state RESP.
- RESP:
  - resp_valid = 1.
  - Go to IDLE when resp_ready = 1; otherwise hold all response outputs stable.
- Strobe exclusivity: mem_memRead and mem_memWrite are never high together, because the memory suppresses both when they overlap. Both are 0 in IDLE and RESP.
- Lanes (little-endian):
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Halfword lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Load extension: byte/half results are sign-extended when signed = 1, else zero-extended.
- Latency from the accept cycle (cycle 0) to resp_valid:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - misaligned: 1
- Throughput: one request in flight; req_ready is low from accept until the response is taken.
- mem_address holds the captured index from RD through WR, so the memory address is stable across negedge.
- Address wrap: addresses at or above 4·2^MEM_AW alias modulo the memory size.

Optional Feature:
- Macro: MAU_ALIGN_CHECK_EN.
- Defined:
  - Misaligned requests are rejected as above.
  - resp_err = 1 and resp_rdata = 0 for a rejected request.
- Undefined:
  - Low address bits are forced to alignment: halfword ignores addr[0]; word ignores addr[1:0].
  - The access proceeds normally.
  - resp_err is tied to 0.

Decomposition:
- Shared package mau_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum.
  - function lane_merge(word, data, size, addr).
  - function lane_extract(word, size, addr, signed).
- Sub-module mau_lane_align (combinational merge/extract), instantiated once; instantiation is optional.

Test Plan:
- Word store 0xDEADBEEF at addr 0x8, then word load at 0x8 → memWrite high exactly 1 cycle at index 2; load resp_rdata = 0xDEADBEEF at latency 2.
- Memory word 3 = 0x11223344; sb 0xAA at addr 0xD → RD then WR cycles; word 3 becomes 0x1122AA44; lbu 0xD → 0x000000AA; lb 0xD → 0xFFFFFFAA.
- Memory word 1 = 0x8000_7FFF; lh at addr 0x6 → 0xFFFF8000; lhu at addr 0x4 → 0x00007FFF.
- With MAU_ALIGN_CHECK_EN: lw at 0x5 → resp_valid at latency 1, resp_err = 1, no memRead/memWrite asserted. Without the macro: same request reads word 1.
- Hold resp_ready = 0 for 4 cycles → resp_valid/resp_rdata stable, req_ready = 0, a second req_valid is not accepted.
- Assert Reset low during the WR cycle of a store before negedge → memWrite drops, target word unchanged, req_ready = 1 after release; addr 0x80 with MEM_AW = 5 accesses word 0.
